// File: rtl/parking_lot_counter_if.sv
`default_nettype none
// ============================================================================
// Module   : parking_lot_counter_if
// Purpose  : Sensor inputs and occupancy count for the parking lot counter.
// Revision : 1.0  initial release
// ============================================================================
interface parking_lot_counter_if #(
  parameter int WIDTH = 3
);
  logic             a;
  logic             b;
  logic [WIDTH-1:0] count;

  modport master (output a, output b, input  count);
  modport slave  (input  a, input  b, output count);
endinterface
`default_nettype wire

// File: rtl/parking_lot_counter.sv
`default_nettype none
// ============================================================================
// Module   : parking_lot_counter
// Purpose  : Two-sensor 4-phase car entry/exit detector with saturating count.
// Revision : 1.0  initial release
// ============================================================================
module parking_lot_counter #(
  parameter int WIDTH     = 3,
  parameter int MAX_COUNT = 7
) (
  input  wire logic             clk,
  input  wire logic             reset,
  parking_lot_counter_if.slave  bus
);

  localparam logic [2:0] c_IDLE   = 3'd0;
  localparam logic [2:0] c_IN_A   = 3'd1;
  localparam logic [2:0] c_IN_AB  = 3'd2;
  localparam logic [2:0] c_IN_B   = 3'd3;
  localparam logic [2:0] c_OUT_B  = 3'd4;
  localparam logic [2:0] c_OUT_BA = 3'd5;
  localparam logic [2:0] c_OUT_A  = 3'd6;

  localparam logic [WIDTH-1:0] c_MAX  = WIDTH'(MAX_COUNT);
  localparam logic [WIDTH-1:0] c_ZERO = '0;
  localparam logic [WIDTH-1:0] c_ONE  = WIDTH'(1);

  logic [2:0]       r_state;
  logic [2:0]       w_next;
  logic [WIDTH-1:0] r_count;
  logic [1:0]       w_ab;
  logic             w_entry;
  logic             w_exit;

  assign w_ab = {bus.a, bus.b};

  always_comb begin
    w_next  = c_IDLE;
    w_entry = 1'b0;
    w_exit  = 1'b0;
    case (r_state)
      c_IDLE: begin
        if (w_ab == 2'b10)      w_next = c_IN_A;
        else if (w_ab == 2'b01) w_next = c_OUT_B;
      end
      c_IN_A: begin
        if (w_ab == 2'b10)      w_next = c_IN_A;
        else if (w_ab == 2'b11) w_next = c_IN_AB;
      end
      c_IN_AB: begin
        if (w_ab == 2'b11)      w_next = c_IN_AB;
        else if (w_ab == 2'b01) w_next = c_IN_B;
        else if (w_ab == 2'b10) w_next = c_IN_A;
      end
      c_IN_B: begin
        if (w_ab == 2'b01)      w_next = c_IN_B;
        else if (w_ab == 2'b11) w_next = c_IN_AB;
        else if (w_ab == 2'b00) w_entry = 1'b1;
      end
      c_OUT_B: begin
        if (w_ab == 2'b01)      w_next = c_OUT_B;
        else if (w_ab == 2'b11) w_next = c_OUT_BA;
      end
      c_OUT_BA: begin
        if (w_ab == 2'b11)      w_next = c_OUT_BA;
        else if (w_ab == 2'b10) w_next = c_OUT_A;
        else if (w_ab == 2'b01) w_next = c_OUT_B;
      end
      c_OUT_A: begin
        if (w_ab == 2'b10)      w_next = c_OUT_A;
        else if (w_ab == 2'b11) w_next = c_OUT_BA;
        else if (w_ab == 2'b00) w_exit = 1'b1;
      end
      default: w_next = c_IDLE;
    endcase
  end

  // Count saturates at both ends; a car seen at capacity is simply not counted.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= c_IDLE;
      r_count <= c_ZERO;
    end else begin
      r_state <= w_next;
      if (w_entry && (r_count < c_MAX))
        r_count <= r_count + c_ONE;
      else if (w_exit && (r_count > c_ZERO))
        r_count <= r_count - c_ONE;
    end
  end

  assign bus.count = r_count;

endmodule
`default_nettype wire

// File: tb/tb_parking_lot_counter.sv
`default_nettype none
// ============================================================================
// Module   : tb_parking_lot_counter
// Purpose  : Directed self-checking bench for parking_lot_counter.
// Revision : 1.0  initial release
// ============================================================================
module tb_parking_lot_counter;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_errors;

  parking_lot_counter_if #(.WIDTH(3)) bus ();

  parking_lot_counter #(.WIDTH(3), .MAX_COUNT(7)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #50 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Apply one sensor pair before an edge, return just after that edge.
  task automatic step(input logic va, input logic vb);
    @(negedge clk);
    bus.a = va;
    bus.b = vb;
    @(posedge clk);
    #1;
  endtask

  task automatic enter(input int exp_before, input int exp_after);
    step(1'b1, 1'b0);
    step(1'b1, 1'b1);
    step(1'b0, 1'b1);
    chk("entry_hold", int'(bus.count), exp_before);
    step(1'b0, 1'b0);
    chk("entry_done", int'(bus.count), exp_after);
  endtask

  task automatic leave(input int exp_before, input int exp_after);
    step(1'b0, 1'b1);
    step(1'b1, 1'b1);
    step(1'b1, 1'b0);
    chk("exit_hold", int'(bus.count), exp_before);
    step(1'b0, 1'b0);
    chk("exit_done", int'(bus.count), exp_after);
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    bus.a    = 1'b0;
    bus.b    = 1'b0;
    reset    = 1'b1;
    @(posedge clk);
    #1;
    chk("reset", int'(bus.count), 0);
    @(negedge clk);
    reset = 1'b0;

    step(1'b0, 1'b1);
    step(1'b0, 1'b0);
    chk("abort_exit", int'(bus.count), 0);

    enter(0, 1);
    enter(1, 2);
    leave(2, 1);
    leave(1, 0);

    leave(0, 0);

    // Invalid jump from IN_A straight to b-only.
    step(1'b1, 1'b0);
    step(1'b0, 1'b1);
    step(1'b0, 1'b0);
    chk("invalid_jump", int'(bus.count), 0);

    step(1'b1, 1'b0);
    step(1'b1, 1'b1);
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    chk("reverse_out", int'(bus.count), 0);

    step(1'b1, 1'b0);
    step(1'b1, 1'b1);
    step(1'b0, 1'b1);
    step(1'b1, 1'b1);
    step(1'b0, 1'b1);
    step(1'b0, 1'b0);
    chk("wobble_entry", int'(bus.count), 1);
    leave(1, 0);

    for (int i = 0; i < 7; i++)
      enter(i, i + 1);
    enter(7, 7);
    for (int i = 7; i > 3; i--)
      leave(i, i - 1);
    chk("before_async", int'(bus.count), 3);

    #20;
    reset = 1'b1;
    #5;
    chk("async_reset", int'(bus.count), 0);
    @(negedge clk);
    reset = 1'b0;
    enter(0, 1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/parking_lot_counter.md
Name: parking_lot_counter

Overview:
Tracks occupancy of a single-lane parking lot using two adjacent optical sensors, a (outer) and b (inner). A 4-phase sensor sequence identifies a car entering or leaving. The block increments or decrements a saturating occupancy count accordingly. It sits directly behind the sensor inputs and drives the occupancy display/logic.

Parameters:
WIDTH, 3, width of count
MAX_COUNT, 7, lot capacity; must be ≤ 2^WIDTH-1

Ports:
clk  input  1  system clock, rising-edge active (nominal 10 MHz, 100 ns period)
reset  input  1  asynchronous, active-high reset
a  input  1  outer sensor, 1 = beam blocked
b  input  1  inner sensor, 1 = beam blocked
count  output  WIDTH  current number of cars in lot, registered

Behaviour:
- One clock; reset is asynchronous and active-high. Reset forces state IDLE and count = 0 immediately; release is synchronous to clk.
- a and b are sampled directly on every rising edge of clk. No synchronizer or debounce; inputs are guaranteed stable around the edge. Sensor pair below is written {a,b}.
- FSM states: IDLE, IN_A, IN_AB, IN_B, OUT_B, OUT_BA, OUT_A.
- IDLE: 10->IN_A; 01->OUT_B; 00 or 11->IDLE.
- IN_A: 10 stay; 11->IN_AB; 00->IDLE (car backed out, no count); 01->IDLE (invalid).
- IN_AB: 11 stay; 01->IN_B; 10->IN_A (backing up); 00->IDLE.
- IN_B: 01 stay; 11->IN_AB; 00->IDLE with entry event; 10->IDLE.
- OUT_B: 01 stay; 11->OUT_BA; 00->IDLE (no count); 10->IDLE.
- OUT_BA: 11 stay; 10->OUT_A; 01->OUT_B; 00->IDLE.
- OUT_A: 10 stay; 11->OUT_BA; 00->IDLE with exit event; 01->IDLE.
- Entry event: on the same rising edge that samples 00 in IN_B, count <= count+1 if count < MAX_COUNT; otherwise count is unchanged (saturate, the car is not counted).
- Exit event: on the same rising edge that samples 00 in OUT_A, count <= count-1 if count > 0; otherwise count is unchanged (no underflow).
- Latency: count is visible one edge after the final 00 is presented, i.e. registered on the edge that samples it.
- Entry and exit events are mutually exclusive by construction. At most one count change occurs per clock.
- A partial sequence leaves count untouched. This covers an aborted sequence, a reversal, or an invalid jump.
- Reset asserted mid-sequence abandons the sequence with no count change and leaves count = 0.
- No wrap-around at any boundary.

Test Plan:
- Reset: hold reset=1 with a=b=0 for 1 cycle -> count=0, state IDLE. Assert reset asynchronously between edges while count=3 -> count goes to 0 immediately.
- Aborted exit after reset: {a,b}=01, then 00 -> count stays 0.
- Two entries then two exits: 10,11,01,00 twice -> count 1 then 2. Then 01,11,10,00 twice -> count 1 then 0. Each change appears on the edge sampling 00.
- Underflow: count=0, apply exit sequence 01,11,10,00 -> count stays 0.
- Fill to capacity: from 0, apply 7 entry sequences -> count steps 1..7. An 8th entry sequence -> count stays 7.
- Reversal: 10,11,10,00 -> no change. 10,11,01,11,01,00 -> exactly +1.
